// File: rtl/bcd_seq_converter.sv
// rtl/bcd_seq_converter.sv - sequential shift-and-add-3 binary-to-BCD converter with start/done handshake
// Optional BCD_SATURATE_EN: an overflowing result loads all-nines instead of the modulo value.
module bcd_seq_converter #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int CW = $clog2(BIN_W + 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]            state;
    logic [BIN_W-1:0]      shreg;
    logic [4*DIGITS-1:0]   scratch;
    logic [CW-1:0]         cnt;
    logic                  ovf_sticky;

    logic [4*DIGITS-1:0]   adj;
    logic [4*DIGITS-1:0]   scratch_sh;
    logic [BIN_W-1:0]      shreg_sh;
    logic                  ovf_next;
    logic [4*DIGITS-1:0]   result;

    always_comb begin
        adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
        scratch_sh = {adj[4*DIGITS-2:0], shreg[BIN_W-1]};
        shreg_sh   = {shreg[BIN_W-2:0], 1'b0};
        // The bit leaving the top digit is worth 10^DIGITS; the scratch keeps the value modulo that.
        ovf_next   = ovf_sticky | adj[4*DIGITS-1];
`ifdef BCD_SATURATE_EN
        result     = ovf_next ? {DIGITS{4'h9}} : scratch_sh;
`else
        result     = scratch_sh;
`endif
    end

    // The final shift result is loaded straight into the outputs so that done, bcd and
    // overflow are all visible, registered, during the DONE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            scratch    <= '0;
            cnt        <= '0;
            ovf_sticky <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bcd        <= '0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        shreg      <= bin;
                        scratch    <= '0;
                        ovf_sticky <= 1'b0;
                        cnt        <= CW'(BIN_W);
                        busy       <= 1'b1;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg      <= shreg_sh;
                    scratch    <= scratch_sh;
                    ovf_sticky <= ovf_next;
                    cnt        <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        bcd      <= result;
                        overflow <= ovf_next;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
